jtframe_ba0_arb: RTL and testbench
==================================

JTFRAME_BA0_ARB -- requirements
Module: jtframe_ba0_arb

Interface
REQ-001 Parameter SDRAMW, default 23: width of every SDRAM word address.
REQ-002 clk  input  1  rom clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rq_cs  input  3  per-requester access request, index 0..2; held high until rq_ok.
REQ-005 rq_we  input  3  per-requester write select, sampled with rq_cs.
REQ-006 rq0_addr, rq1_addr, rq2_addr  input  SDRAMW each  per-requester word address.
REQ-007 rq0_din, rq1_din, rq2_din  input  16 each  per-requester write data.
REQ-008 rq0_din_m, rq1_din_m, rq2_din_m  input  2 each  per-requester byte write mask, active-high per byte.
REQ-009 rq_ok  output  3  per-requester completion flag.
REQ-010 rq0_dout, rq1_dout, rq2_dout  output  16 each  per-requester latched read data.
REQ-011 ba0_addr  output  SDRAMW  bank-0 address to the SDRAM controller.
REQ-012 ba0_rd, ba0_wr  output  1 each  bank-0 read/write strobes.
REQ-013 ba0_din  output  16, ba0_din_m  output  2  bank-0 write data and mask.
REQ-014 ba0_ack  input  1  controller accepted the command.
REQ-015 ba0_rdy  input  1  read data valid on sdram_dout, or write complete.
REQ-016 sdram_dout  input  16  shared SDRAM read data.

Function
REQ-017 FSM states: IDLE, CMD, WAIT, DONE; reset state IDLE.
REQ-018 IDLE: pending = rq_cs AND NOT rq_ok; pick the first pending index at or after rr_ptr, ascending with wrap 2->0; on a pick, latch index, address, we, din and mask, then go to CMD next cycle.
REQ-019 CMD: drive ba0_addr and ba0_din/ba0_din_m from the latched values; hold ba0_rd (we=0) or ba0_wr (we=1) high; on ba0_ack drop the strobe next cycle and go to WAIT.
REQ-020 ba0_ack and ba0_rdy in the same CMD cycle: go straight to DONE and skip WAIT.
REQ-021 WAIT: strobes low, ba0_addr held; on ba0_rdy capture sdram_dout into the granted rqN_dout (reads only), then DONE.
REQ-022 DONE: one cycle; set rq_ok[granted]; rr_ptr becomes granted+1 mod 3; return to IDLE.
REQ-023 Minimum latency from rq_cs rising (bus idle) to rq_ok high: 3 cycles plus controller ack/rdy delay.
REQ-024 rq_ok[n] stays high while rq_cs[n] is high and rqN_addr equals the latched address; it clears the cycle after either condition fails.
REQ-025 A new address on a requester with rq_cs held counts as a new pending request once rq_ok clears.
REQ-026 A requester that drops rq_cs during CMD/WAIT does not abort the transaction: it runs to DONE, rq_ok is not set, and read data is discarded.
REQ-027 rqN_dout changes only on a completed read for requester N.
REQ-028 At most one of ba0_rd/ba0_wr is high at any time; both are low outside CMD.
REQ-029 Simultaneous requests: exactly one grant per pass through IDLE; every pending requester is served within 3 transactions (no starvation).

Reset
REQ-030 rst high: state IDLE, rr_ptr=0, rq_ok=0, ba0_rd=0, ba0_wr=0, ba0_addr=0, ba0_din=0, ba0_din_m=0, rqN_dout=0; takes effect on the next edge, including mid-transaction.
REQ-031 After rst, an outstanding controller ba0_rdy is ignored while in IDLE.

Verification
REQ-032 Single read: rq_cs=001, rq0_addr=0x1234 -> ba0_rd high with ba0_addr=0x1234 until ack; rdy with sdram_dout=0xBEEF -> rq0_dout=0xBEEF, rq_ok=001.
REQ-033 Write: rq_cs=010, rq_we=010, rq1_din=0x55AA, mask=01 -> ba0_wr high, ba0_din=0x55AA, ba0_din_m=01; rdy -> rq_ok=010; rq1_dout unchanged.
REQ-034 Contention: rq_cs=111 from reset, each cleared on its ok -> grant order 0,1,2; reassert all -> next order 0,1,2 again.
REQ-035 Abort: rq_cs[2] dropped during WAIT -> transaction completes, rq_ok stays 000, rq2_dout unchanged.
REQ-036 Same-cycle ack+rdy in CMD -> DONE next cycle with no WAIT, and the data is captured.
REQ-037 rst asserted in WAIT -> all outputs reach their reset values the next cycle; a later rdy pulse causes no rq_ok.

Source files
------------

// File: rtl/jtframe_ba0_arb.sv
// Round-robin arbiter that shares SDRAM bank 0 between three requesters.
// Each request is latched, issued as a rd/wr strobe, then completed through rq_ok.
module jtframe_ba0_arb #(
  parameter int SDRAMW = 32'd23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rq_cs,
  input  logic [2:0]        rq_we,
  input  logic [SDRAMW-1:0] rq0_addr,
  input  logic [SDRAMW-1:0] rq1_addr,
  input  logic [SDRAMW-1:0] rq2_addr,
  input  logic [15:0]       rq0_din,
  input  logic [15:0]       rq1_din,
  input  logic [15:0]       rq2_din,
  input  logic [1:0]        rq0_din_m,
  input  logic [1:0]        rq1_din_m,
  input  logic [1:0]        rq2_din_m,
  output logic [2:0]        rq_ok,
  output logic [15:0]       rq0_dout,
  output logic [15:0]       rq1_dout,
  output logic [15:0]       rq2_dout,
  output logic [SDRAMW-1:0] ba0_addr,
  output logic              ba0_rd,
  output logic              ba0_wr,
  output logic [15:0]       ba0_din,
  output logic [1:0]        ba0_din_m,
  input  logic              ba0_ack,
  input  logic              ba0_rdy,
  input  logic [15:0]       sdram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [1:0]        rr_ptr_r, gnt_r;
  logic              we_r;
  logic [15:0]       rd_data_r;
  logic [15:0]       dout_r [3];
  logic [SDRAMW-1:0] ok_addr_r [3];
  logic [SDRAMW-1:0] rq_addr_s [3];
  logic [15:0]       rq_din_s [3];
  logic [1:0]        rq_mask_s [3];
  logic [2:0]        pending_s, pick_s, keep_s;
  logic              done_hit_s;

  // First pending index at or after ptr, wrapping 2->0; MSB flags a valid pick
  function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] ptr);
    logic [2:0] sum;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      sum = {1'b0, ptr} + 3'(k);
      sum = (sum >= 3'd3) ? sum - 3'd3 : sum;
      res = pend[sum[1:0]] ? {1'b1, sum[1:0]} : res;
    end
    return res;
  endfunction

  // Requester ports gathered into arrays, plus arbitration and completion terms
  always_comb begin
    rq_addr_s[0] = rq0_addr;
    rq_addr_s[1] = rq1_addr;
    rq_addr_s[2] = rq2_addr;
    rq_din_s[0]  = rq0_din;
    rq_din_s[1]  = rq1_din;
    rq_din_s[2]  = rq2_din;
    rq_mask_s[0] = rq0_din_m;
    rq_mask_s[1] = rq1_din_m;
    rq_mask_s[2] = rq2_din_m;
    pending_s    = rq_cs & ~rq_ok;
    pick_s       = rr_pick(pending_s, rr_ptr_r);
    for (int n = 0; n < 3; n++) begin
      keep_s[n] = rq_cs[n] && (rq_addr_s[n] == ok_addr_r[n]);
    end
    // An aborted or re-addressed requester gets neither rq_ok nor data
    done_hit_s = (state_r == DONE) && rq_cs[gnt_r] && (rq_addr_s[gnt_r] == ba0_addr);
  end

  assign rq0_dout = dout_r[0];
  assign rq1_dout = dout_r[1];
  assign rq2_dout = dout_r[2];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) state_nxt_s = CMD;
        else           state_nxt_s = IDLE;
      end
      CMD: begin
        if (ba0_ack && ba0_rdy) state_nxt_s = DONE;
        else if (ba0_ack)       state_nxt_s = WAIT;
        else                    state_nxt_s = CMD;
      end
      WAIT: begin
        if (ba0_rdy) state_nxt_s = DONE;
        else         state_nxt_s = WAIT;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, bank-0 command outputs and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= 2'd0;
      gnt_r     <= 2'd0;
      we_r      <= 1'b0;
      rd_data_r <= 16'd0;
      ba0_addr  <= '0;
      ba0_rd    <= 1'b0;
      ba0_wr    <= 1'b0;
      ba0_din   <= 16'd0;
      ba0_din_m <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s[2]) begin
            gnt_r     <= pick_s[1:0];
            we_r      <= rq_we[pick_s[1:0]];
            ba0_addr  <= rq_addr_s[pick_s[1:0]];
            ba0_din   <= rq_din_s[pick_s[1:0]];
            ba0_din_m <= rq_mask_s[pick_s[1:0]];
            ba0_rd    <= ~rq_we[pick_s[1:0]];
            ba0_wr    <= rq_we[pick_s[1:0]];
          end
        end
        CMD: begin
          if (ba0_ack) begin
            ba0_rd <= 1'b0;
            ba0_wr <= 1'b0;
            if (ba0_rdy) rd_data_r <= sdram_dout;
          end
        end
        WAIT: begin
          if (ba0_rdy) rd_data_r <= sdram_dout;
        end
        DONE: begin
          rr_ptr_r <= (gnt_r == 2'd2) ? 2'd0 : gnt_r + 2'd1;
        end
        default: begin
          ba0_rd <= 1'b0;
          ba0_wr <= 1'b0;
        end
      endcase
    end
  end

  // Completion flags, the address each flag belongs to, and per-requester read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_ok <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        dout_r[n]    <= 16'd0;
        ok_addr_r[n] <= '0;
      end
    end else begin
      rq_ok <= rq_ok & keep_s;
      if (done_hit_s) begin
        rq_ok[gnt_r]     <= 1'b1;
        ok_addr_r[gnt_r] <= ba0_addr;
        if (!we_r) dout_r[gnt_r] <= rd_data_r;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_ba0_arb.sv
// Bench for jtframe_ba0_arb: acts as the SDRAM controller and three requesters,
// predicting grant order, completion flags and read data at transaction level.
module tb_jtframe_ba0_arb;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    rq_cs = 3'b000, rq_we = 3'b000;
  logic [AW-1:0] addr_m [3];
  logic [15:0]   din_v [3];
  logic [1:0]    mask_v [3];
  logic [2:0]    rq_ok;
  logic [15:0]   rq0_dout, rq1_dout, rq2_dout;
  logic [AW-1:0] ba0_addr;
  logic          ba0_rd, ba0_wr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic          ba0_ack = 1'b0, ba0_rdy = 1'b0;
  logic [15:0]   sdram_dout = 16'd0;

  int          n_cmp = 0, n_bad = 0;
  int          ptr_m = 0, last_m = -1;
  logic [15:0] exp_dout [3];

  jtframe_ba0_arb #(.SDRAMW(AW)) dut (
    .clk(clk), .rst(rst), .rq_cs(rq_cs), .rq_we(rq_we),
    .rq0_addr(addr_m[0]), .rq1_addr(addr_m[1]), .rq2_addr(addr_m[2]),
    .rq0_din(din_v[0]), .rq1_din(din_v[1]), .rq2_din(din_v[2]),
    .rq0_din_m(mask_v[0]), .rq1_din_m(mask_v[1]), .rq2_din_m(mask_v[2]),
    .rq_ok(rq_ok), .rq0_dout(rq0_dout), .rq1_dout(rq1_dout), .rq2_dout(rq2_dout),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read and write strobes are never high together
  always @(negedge clk) begin
    if (!rst) chk("rd_wr_exclusive", {31'd0, ba0_rd & ba0_wr}, 32'd0);
  end

  function automatic logic [15:0] dout_of(input int n);
    case (n)
      0:       return rq0_dout;
      1:       return rq1_dout;
      default: return rq2_dout;
    endcase
  endfunction

  task automatic check_douts();
    for (int i = 0; i < 3; i++) chk($sformatf("dout%0d", i), {16'd0, dout_of(i)}, {16'd0, exp_dout[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ok"}, {29'd0, rq_ok}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, ba0_rd, ba0_wr}, 32'd0);
    chk({tag, "_addr"}, {9'd0, ba0_addr}, 32'd0);
    chk({tag, "_din"}, {14'd0, ba0_din_m, ba0_din}, 32'd0);
    for (int i = 0; i < 3; i++) exp_dout[i] = 16'd0;
    check_douts();
  endtask

  // Low two address bits carry the requester index so a wrong grant shows on ba0_addr
  task automatic new_req(input int n);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[1:0] = 2'(n);
    addr_m[n] = a;
    rq_we[n]  = 1'($urandom);
    din_v[n]  = 16'($urandom);
    mask_v[n] = 2'($urandom);
    rq_cs[n]  = 1'b1;
  endtask

  // Served requester keeps rq_ok masking it for one IDLE pass, so others go first
  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr_m + k) % 3;
      if (rq_cs[i] && i != last_m) return i;
    end
    if (last_m >= 0 && rq_cs[last_m]) return last_m;
    return -1;
  endfunction

  task automatic serve(input logic [15:0] data, input int ack_dly, input int rdy_dly,
                       input bit same, input bit abort_in, input bit keep);
    int n, t;
    bit we, abort_;
    logic [2:0] exp_ok;
    n = model_pick();
    if (n < 0) return;
    we = rq_we[n];
    abort_ = abort_in & ~same;
    @(negedge clk);
    chk("ok_clear", {29'd0, rq_ok}, 32'd0);
    t = 0;
    while (!(ba0_rd || ba0_wr) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("strobe_seen", {31'd0, ba0_rd | ba0_wr}, 32'd1);
    if (!(ba0_rd || ba0_wr)) return;
    chk("grant_addr", {9'd0, ba0_addr}, {9'd0, addr_m[n]});
    chk("grant_dir", {30'd0, ba0_rd, ba0_wr}, {30'd0, ~we, we});
    if (we) chk("wr_data", {14'd0, ba0_din_m, ba0_din}, {14'd0, mask_v[n], din_v[n]});
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("strobe_hold", {30'd0, ba0_rd, ba0_wr}, {30'd0, ~we, we});
    end
    ba0_ack = 1'b1;
    ba0_rdy = same;
    sdram_dout = same ? data : ~data;
    @(negedge clk);
    ba0_ack = 1'b0;
    ba0_rdy = 1'b0;
    sdram_dout = ~data;
    if (!same) begin
      chk("wait_strobe_low", {30'd0, ba0_rd, ba0_wr}, 32'd0);
      chk("wait_addr_held", {9'd0, ba0_addr}, {9'd0, addr_m[n]});
      if (abort_) rq_cs[n] = 1'b0;
      for (int i = 0; i < rdy_dly; i++) @(negedge clk);
      ba0_rdy = 1'b1;
      sdram_dout = data;
      @(negedge clk);
      ba0_rdy = 1'b0;
      sdram_dout = ~data;
    end
    chk("done_no_ok_yet", {29'd0, rq_ok}, 32'd0);
    @(negedge clk);
    exp_ok = abort_ ? 3'b000 : 3'(1 << n);
    if (!abort_ && !we) exp_dout[n] = data;
    chk($sformatf("rq_ok_after_%0d", n), {29'd0, rq_ok}, {29'd0, exp_ok});
    check_douts();
    ptr_m = (n + 1) % 3;
    last_m = n;
    if (!abort_) begin
      if (keep) begin
        addr_m[n] = addr_m[n] ^ AW'(4);
        rq_we[n]  = 1'($urandom);
        din_v[n]  = 16'($urandom);
      end else begin
        rq_cs[n] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq_cs = 3'b000;
    repeat (2) @(negedge clk);
    ptr_m = 0;
    last_m = -1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_m[i] = AW'(0);
      din_v[i] = 16'd0;
      mask_v[i] = 2'd0;
      exp_dout[i] = 16'd0;
    end
    do_reset();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single read of 0x1234 returning 0xBEEF
    addr_m[0] = AW'(32'h1234); rq_we[0] = 1'b0; rq_cs[0] = 1'b1;
    serve(16'hBEEF, 2, 1, 1'b0, 1'b0, 1'b0);

    // Write from requester 1 with only the low byte enabled
    addr_m[1] = AW'(32'h4321); rq_we[1] = 1'b1; din_v[1] = 16'h55AA; mask_v[1] = 2'b01;
    rq_cs[1] = 1'b1;
    serve(16'h0F0F, 0, 2, 1'b0, 1'b0, 1'b0);

    // Same-cycle ack and rdy on a read
    new_req(2); rq_we[2] = 1'b0;
    serve(16'hC0DE, 1, 0, 1'b1, 1'b0, 1'b0);

    // Full contention from reset, twice
    do_reset();
    for (int i = 0; i < 3; i++) exp_dout[i] = 16'd0;
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) new_req(i);
      for (int i = 0; i < 3; i++) serve(16'($urandom), 1, 1, 1'b0, 1'b0, 1'b0);
    end

    // Requester 2 read aborted in WAIT
    new_req(2); rq_we[2] = 1'b0;
    serve(16'hDEAD, 0, 2, 1'b0, 1'b1, 1'b0);

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 3; i++) if (!rq_cs[i] && $urandom_range(0, 1) == 0) new_req(i);
      if (rq_cs == 3'b000) new_req($urandom_range(0, 2));
      serve(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset while waiting for rdy; the late rdy must not complete anything
    rq_cs = 3'b000;
    repeat (3) @(negedge clk);
    new_req(0); rq_we[0] = 1'b0;
    for (int t = 0; t < 20 && !ba0_rd; t++) @(negedge clk);
    chk("rst_case_strobe", {31'd0, ba0_rd}, 32'd1);
    ba0_ack = 1'b1;
    @(negedge clk);
    ba0_ack = 1'b0;
    rst = 1'b1;
    rq_cs = 3'b000;
    @(negedge clk);
    check_reset_outputs("rst_in_wait");
    rst = 1'b0;
    ba0_rdy = 1'b1;
    sdram_dout = 16'hA5A5;
    @(negedge clk);
    ba0_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rdy_no_ok", {29'd0, rq_ok}, 32'd0);
    end
    check_douts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
